alu_muldiv_sequencer: RTL
=========================

Name: alu_muldiv_sequencer

Overview:
- Pipeline-facing controller for the EX-stage ALU in the 5-stage datapath.
- Accepts one ALU operation per handshake and completes ADD/SUB/AND/OR in one cycle.
- Runs MUL (shift-add) and DIV (restoring) iteratively over WIDTH cycles, so hazard logic can stall the pipeline on busy.
- Result layout matches the existing ALU: MUL gives a full 2*WIDTH product; DIV gives quotient in the low half and remainder in the high half.

Parameters:
WIDTH, 16, operand width; result width is 2*WIDTH; iteration count for MUL/DIV is WIDTH

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset: asynchronous, active-high
flush  in  1  synchronous abort of any in-flight operation (branch/exception)
req_valid  in  1  operation request
req_ready  out  1  request accepted when req_valid & req_ready at rising edge
req_func  in  3  ALU_FUNC code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 MUL, 101 DIV, 110/111 illegal
req_a  in  WIDTH  operand a, unsigned
req_b  in  WIDTH  operand b, unsigned
res_valid  out  1  one-cycle pulse; result fields valid
res_out  out  2*WIDTH  result; held stable until the next res_valid
res_of  out  1  ADD carry-out or SUB borrow; 0 for all other ops
res_dz  out  1  DIV with b==0
res_illegal  out  1  func 110/111
busy  out  1  MUL or DIV in progress; drives pipeline stall

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state=IDLE
  - req_ready=1
  - res_valid=0, busy=0
  - res_out=0, res_of=0, res_dz=0, res_illegal=0
  - iteration counter=0
- States: IDLE, MUL, DIV, DONE. Accept = req_valid & req_ready & ~flush.
- req_ready=1 in IDLE and DONE, 0 in MUL/DIV. Back-to-back requests are accepted in DONE.
- Single-cycle ops (ADD/SUB/AND/OR/illegal), accepted in cycle 0: result registered at end of cycle 0, state->DONE, res_valid=1 in cycle 1.
- ADD: res_out[WIDTH-1:0]=a+b (mod 2^WIDTH), upper half 0, res_of=carry-out.
- SUB: low half = a-b (mod 2^WIDTH), upper half 0, res_of=(a<b).
- AND/OR: zero-extended bitwise result.
- Illegal: res_out=0, res_illegal=1.
- MUL/DIV, accepted in cycle 0:
  - Operands latched, counter=0, state->MUL/DIV, busy=1 from cycle 1.
  - One iteration per cycle in cycles 1..WIDTH.
  - At end of cycle WIDTH, state->DONE; busy=0 and res_valid=1 in cycle WIDTH+1 (cycle 17 at default).
- MUL: unsigned product, full 2*WIDTH bits.
- DIV: unsigned restoring division; quotient in low half, remainder in high half.
- DIV with b==0: still runs WIDTH iterations; natural outcome is quotient all-ones, remainder=a; res_dz=1.
- DONE: res_valid high exactly one cycle, then state->IDLE unless a new request is accepted (then MUL/DIV/DONE per func). Status flags update only together with res_out.
- flush:
  - Any state goes to IDLE at the next edge; no res_valid for the aborted op; res_out keeps its previous value.
  - flush has priority over a simultaneous req_valid, which is not accepted.
- req_valid while busy: ignored (req_ready=0); the requester must hold. Operand changes during MUL/DIV have no effect.
- Asynchronous reset mid-operation: immediate return to the reset values listed above; the partial result is discarded.

Decomposition:
- Shared package alu_pkg:
  - ALU_FUNC localparams (ADD..DIV, ILLEGAL range)
  - state enum {IDLE, MUL, DIV, DONE}
  - WIDTH default
- One sub-module, alu_muldiv_step: combinational single iteration.
  - Inputs: mode, partial accumulator/remainder, shifted operand.
  - Outputs: next accumulator/remainder and quotient bit.
  - The sequencer owns all registers, the counter and the FSM.

Test Plan:
- Reset mid-MUL (assert rst in cycle 5 after accepting 3x4) -> same cycle: busy=0, req_ready=1, res_out=0; no res_valid afterwards.
- ADD a=0xFFFF b=0x0001 -> res_valid in cycle 1, res_out=0x00000000, res_of=1. SUB a=0x0003 b=0x0005 -> low half 0xFFFE, res_of=1.
- MUL a=0x1234 b=0x5678 -> busy cycles 1..16, res_valid only in cycle 17, res_out=0x06260060, res_of=0.
- DIV a=100 b=7 -> res_out=0x0002000E at cycle 17. DIV a=0x00AB b=0 -> res_out=0x00ABFFFF, res_dz=1.
- Back-to-back: MUL 3x4 then ADD 1+1 presented during the MUL -> held off until DONE cycle 17, accepted there; results 12 (cycle 17) then 2 (cycle 18).
- flush in cycle 8 of a DIV, with req_valid high in the same cycle -> IDLE next cycle, no res_valid, request not accepted, res_out unchanged. func=3'b111 -> res_illegal=1, res_out=0 in cycle 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU sequencer: function codes,
// FSM state encoding and the default operand width.
package alu_pkg;

  localparam int WIDTH_DEFAULT = 16;

  localparam logic [2:0] FUNC_ADD = 3'b000;
  localparam logic [2:0] FUNC_SUB = 3'b001;
  localparam logic [2:0] FUNC_AND = 3'b010;
  localparam logic [2:0] FUNC_OR  = 3'b011;
  localparam logic [2:0] FUNC_MUL = 3'b100;
  localparam logic [2:0] FUNC_DIV = 3'b101;
  // 3'b110 and 3'b111 are illegal and complete in one cycle with res_illegal set.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/alu_muldiv_sequencer_if.sv
// Request/result bundle between the pipeline (master) and the ALU sequencer (slave).
interface alu_muldiv_sequencer_if
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic               req_valid;
  logic               req_ready;
  logic [2:0]         req_func;
  logic [WIDTH-1:0]   req_a;
  logic [WIDTH-1:0]   req_b;
  logic               res_valid;
  logic [2*WIDTH-1:0] res_out;
  logic               res_of;
  logic               res_dz;
  logic               res_illegal;
  logic               busy;

  modport master (
    output req_valid, req_func, req_a, req_b,
    input  req_ready, res_valid, res_out, res_of, res_dz, res_illegal, busy
  );

  modport slave (
    input  req_valid, req_func, req_a, req_b,
    output req_ready, res_valid, res_out, res_of, res_dz, res_illegal, busy
  );

endinterface

// File: rtl/alu_muldiv_step.sv
// One combinational iteration of shift-add multiply or restoring divide.
// acc is the product high half (MUL) or the partial remainder (DIV).
module alu_muldiv_step
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] acc_o,
  output logic             bit_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    // NOTE: every output gets a value before any branch so no latch is inferred.
    acc_o   = acc_i;
    bit_o   = 1'b0;
    sum     = {1'b0, acc_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
    shifted = {acc_i, lo_i[WIDTH-1]};
    diff    = shifted - {1'b0, opnd_i};

    if (is_div_i) begin
      // A borrow out of the trial subtraction means the divisor did not fit: restore.
      if (diff[WIDTH]) begin
        acc_o = shifted[WIDTH-1:0];
        bit_o = 1'b0;
      end else begin
        acc_o = diff[WIDTH-1:0];
        bit_o = 1'b1;
      end
    end else begin
      // MUL: bit_o is the product bit that drops out of the high half into the low half.
      acc_o = sum[WIDTH:1];
      bit_o = sum[0];
    end
  end

endmodule

// File: rtl/alu_muldiv_sequencer.sv
// EX-stage ALU controller: single-cycle ADD/SUB/AND/OR, iterative MUL/DIV
// over WIDTH cycles with busy for pipeline stall, flush abort.
module alu_muldiv_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  alu_muldiv_sequencer_if.slave         bus
);

  localparam int                CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(WIDTH - 1);

  state_e               state_q,   state_d;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  logic [WIDTH-1:0]     acc_q,     acc_d;
  logic [WIDTH-1:0]     lo_q,      lo_d;
  logic [WIDTH-1:0]     opnd_q,    opnd_d;
  logic                 dz_pend_q, dz_pend_d;
  logic [2*WIDTH-1:0]   res_out_q, res_out_d;
  logic                 res_of_q,  res_of_d;
  logic                 res_dz_q,  res_dz_d;
  logic                 res_ill_q, res_ill_d;

  logic                 ready;
  logic                 accept;
  logic [WIDTH:0]       add_sum;
  logic [WIDTH:0]       sub_diff;
  logic [WIDTH-1:0]     step_acc;
  logic                 step_bit;
  logic [WIDTH-1:0]     lo_next;

  assign ready    = (state_q == IDLE) || (state_q == DONE);
  assign accept   = bus.req_valid & ready & ~flush;
  assign add_sum  = {1'b0, bus.req_a} + {1'b0, bus.req_b};
  assign sub_diff = {1'b0, bus.req_a} - {1'b0, bus.req_b};

  alu_muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .is_div_i (state_q == DIV),
    .acc_i    (acc_q),
    .lo_i     (lo_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc),
    .bit_o    (step_bit)
  );

  // MUL shifts the multiplier right while product bits enter at the top;
  // DIV shifts the dividend out at the top while quotient bits enter at the bottom.
  assign lo_next = (state_q == DIV) ? {lo_q[WIDTH-2:0], step_bit}
                                    : {step_bit, lo_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    dz_pend_d = dz_pend_q;
    res_out_d = res_out_q;
    res_of_d  = res_of_q;
    res_dz_d  = res_dz_q;
    res_ill_d = res_ill_q;

    if (flush) begin
      // Abort wins over everything, including a simultaneous request and a final iteration.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          state_d = IDLE;
          if (accept) begin
            case (bus.req_func)
              FUNC_ADD: begin
                state_d   = DONE;
                res_out_d = {{WIDTH{1'b0}}, add_sum[WIDTH-1:0]};
                res_of_d  = add_sum[WIDTH];
                res_dz_d  = 1'b0;
                res_ill_d = 1'b0;
              end
              FUNC_SUB: begin
                state_d   = DONE;
                res_out_d = {{WIDTH{1'b0}}, sub_diff[WIDTH-1:0]};
                res_of_d  = sub_diff[WIDTH];
                res_dz_d  = 1'b0;
                res_ill_d = 1'b0;
              end
              FUNC_AND: begin
                state_d   = DONE;
                res_out_d = {{WIDTH{1'b0}}, bus.req_a & bus.req_b};
                res_of_d  = 1'b0;
                res_dz_d  = 1'b0;
                res_ill_d = 1'b0;
              end
              FUNC_OR: begin
                state_d   = DONE;
                res_out_d = {{WIDTH{1'b0}}, bus.req_a | bus.req_b};
                res_of_d  = 1'b0;
                res_dz_d  = 1'b0;
                res_ill_d = 1'b0;
              end
              FUNC_MUL: begin
                state_d   = MUL;
                cnt_d     = '0;
                acc_d     = '0;
                lo_d      = bus.req_b;
                opnd_d    = bus.req_a;
                dz_pend_d = 1'b0;
              end
              FUNC_DIV: begin
                state_d   = DIV;
                cnt_d     = '0;
                acc_d     = '0;
                lo_d      = bus.req_a;
                opnd_d    = bus.req_b;
                dz_pend_d = (bus.req_b == '0);
              end
              default: begin
                state_d   = DONE;
                res_out_d = '0;
                res_of_d  = 1'b0;
                res_dz_d  = 1'b0;
                res_ill_d = 1'b1;
              end
            endcase
          end
        end
        MUL, DIV: begin
          acc_d = step_acc;
          lo_d  = lo_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) begin
            state_d   = DONE;
            cnt_d     = '0;
            res_out_d = {step_acc, lo_next};
            res_of_d  = 1'b0;
            res_dz_d  = dz_pend_q;
            res_ill_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: non-blocking assignments here so every register samples the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: datapath registers are reset too; they are plain flops, not a RAM, and res_out is observable.
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      dz_pend_q <= 1'b0;
      res_out_q <= '0;
      res_of_q  <= 1'b0;
      res_dz_q  <= 1'b0;
      res_ill_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      dz_pend_q <= dz_pend_d;
      res_out_q <= res_out_d;
      res_of_q  <= res_of_d;
      res_dz_q  <= res_dz_d;
      res_ill_q <= res_ill_d;
    end
  end

  assign bus.req_ready   = ready;
  assign bus.res_valid   = (state_q == DONE);
  assign bus.busy        = (state_q == MUL) || (state_q == DIV);
  assign bus.res_out     = res_out_q;
  assign bus.res_of      = res_of_q;
  assign bus.res_dz      = res_dz_q;
  assign bus.res_illegal = res_ill_q;

endmodule
